rr_mux_n: RTL and testbench

Parametrised N-channel, W-bit registered multiplexer with a valid/ready handshake on every input and on the output. It is the successor of the fixed 8-to-1 32-bit combinational mux. It adds a runtime choice between fixed (`sel`-driven) selection and round-robin arbitration, plus a one-entry output register with backpressure. It sits between register-file/ROM read ports and the datapath consumer wherever several sources compete for one bus.

---
 rtl/rr_mux_n_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/rr_mux_n.sv | 79 +++++++
 tb/tb_rr_mux_n.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rr_mux_n_pkg.sv
// Shared definitions for the rr_mux_n block.
//   MODE_FIXED / MODE_RR : encodings of the 'mode' input (0 = sel-driven, 1 = round-robin).
package rr_mux_n_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : per-channel request vector
//   ptr       : highest-priority channel index (must be < CHANNELS)
//   grant     : one-hot grant, zero when nothing requests
//   grant_idx : binary index of the granted channel
//   any       : at least one request present
module rr_arbiter #(
  parameter int CHANNELS = 8,
  parameter int PW       = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [PW-1:0]       ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [PW-1:0]       grant_idx,
  output logic                any
);
  localparam logic [PW:0] CH = (PW+1)'(CHANNELS);

  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-1:0]   rot;
  logic [PW-1:0]         off;
  logic [PW:0]           sum;

  // Rotating a doubled request vector puts channel 'ptr' at bit 0, so the
  // lowest set bit is the first requester at or above ptr, modulo CHANNELS.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[CHANNELS-1:0];
  assign any = |rot;

  always_comb begin
    off = '0;
    for (int i = CHANNELS-1; i >= 0; i--)
      if (rot[i]) off = PW'(i);
    // Undo the rotation; explicit wrap because CHANNELS need not be a power of two.
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= CH) sum = sum - CH;
    grant_idx = sum[PW-1:0];
    grant     = any ? (CHANNELS'(1) << grant_idx) : '0;
  end
endmodule

// File: rtl/rr_mux_n.sv
// N-channel registered mux with valid/ready on every input and the output.
// Fixed (sel) or round-robin selection, one-entry output register with backpressure.
//   clk, rst_n (sync, active low)
//   mode, sel                : selection control
//   in_data/in_valid/in_ready: flattened per-channel inputs, channel i at [i*WIDTH +: WIDTH]
//   out_data/out_chan/out_valid/out_ready : registered output and its source channel
module rr_mux_n
  import rr_mux_n_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);
  localparam int PW = $clog2(CHANNELS);

  logic [PW-1:0]       ptr;
  logic [CHANNELS-1:0] arb_grant, fix_grant;
  logic [PW-1:0]       arb_idx, fix_idx, g_idx;
  logic                arb_any, fix_any, g_any;
  logic                space, xfer;

  rr_arbiter #(.CHANNELS(CHANNELS), .PW(PW)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Fixed select: compare against each legal index so an out-of-range sel
  // simply matches nothing instead of indexing past in_valid.
  always_comb begin
    fix_any   = 1'b0;
    fix_idx   = '0;
    fix_grant = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (sel == SEL_W'(i) && in_valid[i]) begin
        fix_any      = 1'b1;
        fix_idx      = PW'(i);
        fix_grant[i] = 1'b1;
      end
  end

  assign g_any    = (mode == MODE_RR) ? arb_any : fix_any;
  assign g_idx    = (mode == MODE_RR) ? arb_idx : fix_idx;
  assign space    = !out_valid || out_ready;
  assign xfer     = rst_n && g_any && space;
  assign in_ready = xfer ? ((mode == MODE_RR) ? arb_grant : fix_grant) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      // A drain in the same cycle is implied: the register reloads, valid stays set.
      out_valid <= 1'b1;
      out_data  <= in_data[g_idx*WIDTH +: WIDTH];
      out_chan  <= SEL_W'(g_idx);
      if (mode == MODE_RR)
        ptr <= (g_idx == PW'(CHANNELS-1)) ? '0 : g_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_mux_n.sv
module tb_rr_mux_n;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 8-channel instance; sel widened to 4 bits so an out-of-range sel (9) is expressible.
  logic          mode8;
  logic [3:0]    sel8;
  logic [255:0]  din8;
  logic [7:0]    vin8, rdy8;
  logic [31:0]   dout8;
  logic [3:0]    chan8;
  logic          ov8, ordy8;

  // 5-channel instance, 8-bit data.
  logic          mode5;
  logic [2:0]    sel5;
  logic [39:0]   din5;
  logic [4:0]    vin5, rdy5;
  logic [7:0]    dout5;
  logic [2:0]    chan5;
  logic          ov5, ordy5;

  int vecs = 0;
  int miss = 0;

  rr_mux_n #(.WIDTH(32), .CHANNELS(8), .SEL_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .mode(mode8), .sel(sel8), .in_data(din8),
    .in_valid(vin8), .in_ready(rdy8), .out_data(dout8), .out_chan(chan8),
    .out_valid(ov8), .out_ready(ordy8));

  rr_mux_n #(.WIDTH(8), .CHANNELS(5)) u5 (
    .clk(clk), .rst_n(rst_n), .mode(mode5), .sel(sel5), .in_data(din5),
    .in_valid(vin5), .in_ready(rdy5), .out_data(dout5), .out_chan(chan5),
    .out_valid(ov5), .out_ready(ordy5));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) din8[i*32 +: 32] = 32'hA5A5_0000 | i;
    for (int i = 0; i < 5; i++) din5[i*8 +: 8] = 8'h50 + 8'(i);
    mode5 = 1'b1; sel5 = 3'd0; vin5 = '0; ordy5 = 1'b1;

    // Reset with every channel requesting
    rst_n = 1'b0; mode8 = 1'b1; sel8 = 4'd0; vin8 = 8'hFF; ordy8 = 1'b1;
    tick(); tick();
    chk("rst_out_valid", 64'(ov8), 64'd0);
    chk("rst_out_data", 64'(dout8), 64'd0);
    chk("rst_out_chan", 64'(chan8), 64'd0);
    chk("rst_in_ready", 64'(rdy8), 64'd0);

    // Round-robin fairness: 0..7 then wrap to 0
    rst_n = 1'b1; settle();
    chk("rr_first_ready", 64'(rdy8), 64'h01);
    tick();
    chk("rr_chan0", 64'(chan8), 64'd0);
    chk("rr_data0", 64'(dout8), 64'hA5A5_0000);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rr_seq_chan", 64'(chan8), 64'(k % 8));
      chk("rr_seq_data", 64'(dout8), 64'(32'hA5A5_0000 | (k % 8)));
    end
    // ptr now 1

    // Fixed mode, sel = 5
    mode8 = 1'b0; sel8 = 4'd5; vin8 = 8'h20; settle();
    chk("fix_ready", 64'(rdy8), 64'h20);
    tick();
    chk("fix_data", 64'(dout8), 64'hA5A5_0005);
    chk("fix_chan", 64'(chan8), 64'd5);
    // sel out of range: no grant, register drains
    sel8 = 4'd9; vin8 = 8'hFF; settle();
    chk("fix_oor_ready", 64'(rdy8), 64'd0);
    tick();
    chk("fix_oor_valid", 64'(ov8), 64'd0);
    chk("fix_oor_hold", 64'(dout8), 64'hA5A5_0005);

    // Backpressure
    sel8 = 4'd3; vin8 = 8'h08;
    tick();
    chk("bp_load", 64'(dout8), 64'hA5A5_0003);
    ordy8 = 1'b0; sel8 = 4'd6; vin8 = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("bp_stall_ready", 64'(rdy8), 64'd0);
      tick();
      chk("bp_stall_data", 64'(dout8), 64'hA5A5_0003);
      chk("bp_stall_valid", 64'(ov8), 64'd1);
    end
    ordy8 = 1'b1; settle();
    chk("bp_release_ready", 64'(rdy8), 64'h40);
    tick();
    chk("bp_reload_data", 64'(dout8), 64'hA5A5_0006);
    chk("bp_reload_valid", 64'(ov8), 64'd1);

    // Mode switch: move ptr to 3 via ch2, do fixed transfers, return to RR
    mode8 = 1'b1; vin8 = 8'h04; settle();
    chk("ms_rr_ready", 64'(rdy8), 64'h04);
    tick();
    chk("ms_rr_chan", 64'(chan8), 64'd2);
    mode8 = 1'b0; sel8 = 4'd0; vin8 = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ms_fix_chan", 64'(chan8), 64'd0);
    end
    mode8 = 1'b1; settle();
    chk("ms_back_ready", 64'(rdy8), 64'h08);
    tick();
    chk("ms_back_chan", 64'(chan8), 64'd3);
    vin8 = 8'h03; settle();
    chk("ms_wrap_ready", 64'(rdy8), 64'h01);
    tick();
    chk("ms_wrap_chan", 64'(chan8), 64'd0);

    // Reset while holding a word
    vin8 = 8'hFF; rst_n = 1'b0; settle();
    chk("mrst_ready", 64'(rdy8), 64'd0);
    tick();
    chk("mrst_valid", 64'(ov8), 64'd0);
    chk("mrst_data", 64'(dout8), 64'd0);
    rst_n = 1'b1; settle();
    chk("mrst_ptr_ready", 64'(rdy8), 64'h01);
    tick();
    chk("mrst_chan", 64'(chan8), 64'd0);
    vin8 = 8'h00;

    // Non-power-of-two: move ptr to 2, then alternate ch4 / ch1
    vin5 = 5'b00010; settle();
    chk("np2_ready1", 64'(rdy5), 64'h02);
    tick();
    chk("np2_chan1", 64'(chan5), 64'd1);
    vin5 = 5'b10010; settle();
    chk("np2_ready4", 64'(rdy5), 64'h10);
    tick();
    chk("np2_g4", 64'(chan5), 64'd4);
    chk("np2_d4", 64'(dout5), 64'h54);
    settle();
    chk("np2_wrap_ready", 64'(rdy5), 64'h02);
    tick();
    chk("np2_g1", 64'(chan5), 64'd1);
    tick();
    chk("np2_g4b", 64'(chan5), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
